// File: rtl/field_mask_sequencer_pkg.sv
// Shared types and helpers for the field-mask capture/report sequencer.
package field_mask_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REPORT, DONE} state_e;

  // Upper bound on channel word width handled by field_keep.
  localparam int MAX_W = 256;

  function automatic int nfield(input int width, input int field);
    return width / field;
  endfunction

  // Keeps bit b of word when the mask bit of the field containing b is set.
  function automatic logic [MAX_W-1:0] field_keep(input logic [MAX_W-1:0] word,
                                                  input logic [MAX_W-1:0] mask,
                                                  input int field);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int b = 0; b < MAX_W; b++) begin
      if (mask[b / field]) res[b] = word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/field_mask_sequencer_if.sv
// Start/capture inputs and valid/ready report outputs of the sequencer.
interface field_mask_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int NCHAN  = 2,
  parameter int NFIELD = 4,
  parameter int CNT_W  = 8
);
  logic                      start;
  logic [NCHAN*WIDTH-1:0]    load_data;
  logic [NCHAN*NFIELD-1:0]   field_mask;
  logic                      out_valid;
  logic                      out_ready;
  logic [NCHAN*WIDTH-1:0]    out_raw;
  logic [NCHAN*WIDTH-1:0]    out_masked;
  logic                      done;
  logic [CNT_W-1:0]          cyc;

  modport master (
    output start, load_data, field_mask, out_ready,
    input  out_valid, out_raw, out_masked, done, cyc
  );

  modport slave (
    input  start, load_data, field_mask, out_ready,
    output out_valid, out_raw, out_masked, done, cyc
  );
endinterface

// File: rtl/field_mask_sequencer_masker.sv
// Combinational per-channel field zeroing of one captured word.
module field_masker
  import field_mask_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FIELD = 4,
  localparam int NF   = WIDTH / FIELD
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [NF-1:0]    mask_i,
  output logic [WIDTH-1:0] word_o
);
  logic [MAX_W-1:0] word_ext;
  logic [MAX_W-1:0] mask_ext;

  assign word_ext = MAX_W'(word_i);
  assign mask_ext = MAX_W'(mask_i);
  assign word_o   = WIDTH'(field_keep(word_ext, mask_ext, FIELD));

endmodule

// File: rtl/field_mask_sequencer.sv
// Cycle-scheduled capture-and-report sequencer: clear, capture, report via valid/ready.
//   state  | meaning
//   IDLE   | waiting for start, cyc held at 0
//   RUN    | stepping cyc 0..REPORT_CYC; clear at 0, capture at LOAD_CYC
//   REPORT | out_valid high, cyc frozen, waiting for out_ready
//   DONE   | done high, outputs held, waiting for start
module field_mask_sequencer
  import field_mask_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FIELD      = 4,
  parameter int NCHAN      = 2,
  parameter int LOAD_CYC   = 2,
  parameter int REPORT_CYC = 4,
  parameter int CNT_W      = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  field_mask_sequencer_if.slave bus
);
  localparam int NFIELD = nfield(WIDTH, FIELD);
  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_CYC);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPORT_CYC);

  if (FIELD <= 0 || WIDTH % FIELD != 0) begin : g_bad_field
    $error("field_mask_sequencer: WIDTH must be a multiple of FIELD");
  end
  if (WIDTH > MAX_W) begin : g_bad_width
    $error("field_mask_sequencer: WIDTH exceeds MAX_W");
  end
  if (!(LOAD_CYC < REPORT_CYC) || REPORT_CYC >= (1 << CNT_W)) begin : g_bad_cyc
    $error("field_mask_sequencer: need LOAD_CYC < REPORT_CYC < 2**CNT_W");
  end
  if (NCHAN < 1) begin : g_bad_nchan
    $error("field_mask_sequencer: NCHAN must be at least 1");
  end

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cyc_q, cyc_d;
  logic [NCHAN*WIDTH-1:0]    data_q, data_d;
  logic [NCHAN*NFIELD-1:0]   mask_q, mask_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        // Later matches override earlier ones, so capture wins if LOAD_CYC is 0.
        if (cyc_q == '0) begin
          data_d = '0;
          mask_d = '0;
        end
        if (cyc_q == LOAD_C) begin
          data_d = bus.load_data;
          mask_d = bus.field_mask;
        end
        if (cyc_q == REP_C) begin
          state_d = REPORT;
          valid_d = 1'b1;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      REPORT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cyc_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    field_masker #(.WIDTH(WIDTH), .FIELD(FIELD)) u_masker (
      .word_i (data_q[c*WIDTH +: WIDTH]),
      .mask_i (mask_q[c*NFIELD +: NFIELD]),
      .word_o (bus.out_masked[c*WIDTH +: WIDTH])
    );
  end

  assign bus.out_raw   = data_q;
  assign bus.out_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.cyc       = cyc_q;

endmodule

// File: tb/tb_field_mask_sequencer.sv
// Directed and randomized runs of field_mask_sequencer against an arithmetic reference model.
module tb_field_mask_sequencer;
  localparam int WIDTH      = 16;
  localparam int FIELD      = 4;
  localparam int NCHAN      = 2;
  localparam int LOAD_CYC   = 2;
  localparam int REPORT_CYC = 4;
  localparam int CNT_W      = 8;
  localparam int NF         = WIDTH / FIELD;
  localparam int DW         = NCHAN * WIDTH;
  localparam int MW         = NCHAN * NF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  field_mask_sequencer_if #(.WIDTH(WIDTH), .NCHAN(NCHAN), .NFIELD(NF), .CNT_W(CNT_W)) bus_if ();

  field_mask_sequencer #(
    .WIDTH(WIDTH), .FIELD(FIELD), .NCHAN(NCHAN),
    .LOAD_CYC(LOAD_CYC), .REPORT_CYC(REPORT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per field, keep the field value when its mask bit is set, via shifts and sums.
  function automatic logic [DW-1:0] model_mask(input logic [DW-1:0] data, input logic [MW-1:0] mask);
    longint unsigned d, m, r, fld;
    d = 64'(data);
    m = 64'(mask);
    r = 0;
    for (int c = 0; c < NCHAN; c++) begin
      for (int i = 0; i < NF; i++) begin
        fld = (d >> (c*WIDTH + i*FIELD)) % (64'd1 << FIELD);
        if (((m >> (c*NF + i)) & 1) == 1) r = r + (fld << (c*WIDTH + i*FIELD));
      end
    end
    return DW'(r);
  endfunction

  // Entered at a negedge with the DUT in IDLE or DONE; leaves at a negedge in DONE.
  task automatic do_run(input logic [DW-1:0] data, input logic [MW-1:0] mask,
                        input int stall, input bit poke_start);
    logic [DW-1:0] exp_m;
    exp_m = model_mask(data, mask);
    bus_if.load_data  = data;
    bus_if.field_mask = mask;
    bus_if.start      = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("run_cyc0", 64'(bus_if.cyc), 64'd0);
    check("run_done_clr", 64'(bus_if.done), 64'd0);
    check("run_valid0", 64'(bus_if.out_valid), 64'd0);
    for (int k = 1; k <= REPORT_CYC; k++) begin
      @(negedge clk);
      check($sformatf("run_cyc%0d", k), 64'(bus_if.cyc), 64'(k));
      check("run_valid_low", 64'(bus_if.out_valid), 64'd0);
      check("run_done_low", 64'(bus_if.done), 64'd0);
      if (k <= LOAD_CYC) begin
        check("pre_cap_raw", 64'(bus_if.out_raw), 64'd0);
        check("pre_cap_masked", 64'(bus_if.out_masked), 64'd0);
      end
      bus_if.start = (k == 1) && poke_start;
      if (k == LOAD_CYC + 1) bus_if.load_data = DW'($urandom);
    end
    bus_if.start = 1'b0;
    @(negedge clk);
    check("rep_valid", 64'(bus_if.out_valid), 64'd1);
    check("rep_cyc", 64'(bus_if.cyc), 64'(REPORT_CYC));
    check("rep_raw", 64'(bus_if.out_raw), 64'(data));
    check("rep_masked", 64'(bus_if.out_masked), 64'(exp_m));
    for (int s = 0; s < stall; s++) begin
      bus_if.out_ready = 1'b0;
      @(negedge clk);
      check("bp_valid", 64'(bus_if.out_valid), 64'd1);
      check("bp_cyc", 64'(bus_if.cyc), 64'(REPORT_CYC));
      check("bp_raw", 64'(bus_if.out_raw), 64'(data));
      check("bp_masked", 64'(bus_if.out_masked), 64'(exp_m));
      check("bp_done", 64'(bus_if.done), 64'd0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("fin_valid", 64'(bus_if.out_valid), 64'd0);
    check("fin_done", 64'(bus_if.done), 64'd1);
    check("fin_raw_hold", 64'(bus_if.out_raw), 64'(data));
    check("fin_masked_hold", 64'(bus_if.out_masked), 64'(exp_m));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.load_data  = '0;
    bus_if.field_mask = '0;
    bus_if.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_cyc", 64'(bus_if.cyc), 64'd0);
    check("rst_raw", 64'(bus_if.out_raw), 64'd0);
    check("rst_masked", 64'(bus_if.out_masked), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cyc", 64'(bus_if.cyc), 64'd0);
    check("idle_valid", 64'(bus_if.out_valid), 64'd0);

    // Basic run, immediate ready.
    do_run({16'h0000, 16'habcd}, {4'b0000, 4'b1101}, 0, 1'b0);
    check("tp1_masked_ch0", 64'(bus_if.out_masked[15:0]), 64'h0000_0000_0000_ab0d);

    // Backpressure for five cycles.
    do_run(DW'($urandom), MW'($urandom), 5, 1'b0);

    // Multi-channel masking.
    do_run({16'hffff, 16'h1234}, {4'b1010, 4'b0000}, 1, 1'b0);
    check("tp3_masked", 64'(bus_if.out_masked), 64'h0000_0000_f0f0_0000);

    // Reset while the report is pending.
    bus_if.load_data  = 32'hdead_beef;
    bus_if.field_mask = 8'hff;
    bus_if.start      = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (REPORT_CYC + 1) @(negedge clk);
    check("mid_valid_pre", 64'(bus_if.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_if.out_valid), 64'd0);
    check("mid_rst_done", 64'(bus_if.done), 64'd0);
    check("mid_rst_cyc", 64'(bus_if.cyc), 64'd0);
    check("mid_rst_raw", 64'(bus_if.out_raw), 64'd0);
    check("mid_rst_masked", 64'(bus_if.out_masked), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run after reset with a stray start during RUN.
    do_run(DW'($urandom), MW'($urandom), 2, 1'b1);

    // Restart from DONE.
    do_run({16'h0000, 16'h00ff}, {4'b0000, 4'b0011}, 0, 1'b0);
    check("tp6_masked_ch0", 64'(bus_if.out_masked[15:0]), 64'h0000_0000_0000_00ff);

    for (int r = 0; r < 8; r++) begin
      do_run(DW'($urandom), MW'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_mask_sequencer.md
Name: field_mask_sequencer

Overview:
- Parametrised, multi-channel capture-and-report sequencer.
- Runs a cycle-scheduled program: clear the channel registers, capture words on a programmed cycle, then report the raw words and field-masked copies on a later cycle through a valid/ready handshake.
- Serves as the regression building block for scheduled-capture and concatenation/field-zeroing checks.
- Write and read of the cycle counter live in one sequential process, so the block has no cross-process ordering hazard.

Parameters:
- WIDTH, 16: bits per channel word.
- FIELD, 4: bits per maskable field; WIDTH % FIELD == 0 is required.
- NCHAN, 2: number of independent channels.
- LOAD_CYC, 2: run cycle on which load_data/field_mask are captured.
- REPORT_CYC, 4: run cycle on which the report is raised; must satisfy LOAD_CYC < REPORT_CYC < 2**CNT_W.
- CNT_W, 8: cycle counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- load_data  in  NCHAN*WIDTH  channel words; channel c occupies [c*WIDTH +: WIDTH].
- field_mask  in  NCHAN*NFIELD  per-field keep bits; channel c occupies [c*NFIELD +: NFIELD]; NFIELD = WIDTH/FIELD.
- out_valid  out  1  report valid.
- out_ready  in  1  report accepted by the consumer.
- out_raw  out  NCHAN*WIDTH  captured words.
- out_masked  out  NCHAN*WIDTH  captured words with unkept fields forced to zero.
- done  out  1  run complete; sticky until the next start.
- cyc  out  CNT_W  current run cycle.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, cyc = 0, all data and mask registers = 0, out_valid = 0, done = 0.
- IDLE: cyc holds at 0. start = 1 moves to RUN on the next edge, with cyc = 0.
- RUN, on each edge, evaluated in this order within one process:
  - cyc == 0: clear data and mask registers to 0.
  - cyc == LOAD_CYC: capture load_data and field_mask for all channels.
  - cyc == REPORT_CYC: move to REPORT and set out_valid = 1.
  - Otherwise, and after the comparisons above: cyc <= cyc + 1. Every value 0..REPORT_CYC is visited exactly once; none is skipped.
- REPORT:
  - cyc freezes at REPORT_CYC.
  - out_valid stays 1, and out_raw/out_masked stay stable, until out_ready = 1 is sampled.
  - On that edge: out_valid = 0, done = 1, state = DONE.
  - out_ready = 1 in the same cycle out_valid first rises is a valid single-cycle transfer.
- DONE:
  - done = 1; outputs hold their last values.
  - start = 1 returns to RUN with cyc = 0 and done cleared on the same edge.
- start is ignored in RUN and REPORT.
- Masking: field i of channel c in out_masked equals the captured data field when mask bit i = 1, else FIELD'b0. out_raw carries the unmodified captured word.
- Before the capture on cyc == LOAD_CYC, both outputs show the cleared value 0.
- Reset mid-run or mid-handshake aborts immediately. No partial report is emitted.
- Elaboration fails with $error if any parameter constraint is violated.

Decomposition:
- Package field_mask_pkg holds:
  - state enum {IDLE, RUN, REPORT, DONE}
  - function nfield(WIDTH, FIELD)
  - function field_keep(word, mask), which performs the masking.
- One sub-module, field_masker: combinational, parametrised by WIDTH/FIELD, instantiated once per channel in a generate loop.
- FSM, counter and capture registers stay in the top module.

Test Plan:
- Defaults; start at cycle 0; load_data ch0 = 16'habcd, mask ch0 = 4'b1101 -> at cyc == 4, out_valid = 1, out_raw ch0 = 16'habcd, out_masked ch0 = 16'hab0d; out_ready = 1 -> done = 1 on the next edge.
- Backpressure: out_ready held 0 for 5 cycles -> out_valid stays 1, outputs stable, cyc = 4 throughout; ready = 1 -> done = 1 on the next edge.
- Multi-channel: ch0 = 16'h1234 with mask 4'b0000, ch1 = 16'hffff with mask 4'b1010 -> masked ch0 = 16'h0000, masked ch1 = 16'hf0f0.
- Counter integrity: monitor cyc across a run -> sequence 0,1,2,3,4 with no gap or repeat. load_data changed at cyc = 3 -> not captured.
- Reset mid-REPORT: rst_n = 0 while out_valid = 1 -> out_valid, done, cyc and data all 0 immediately. Next start gives a clean run.
- Restart and ignore: start pulsed during RUN -> no effect. start in DONE with new data 16'h00ff and mask 4'b0011 -> second report gives masked 16'h00ff, done = 0 during the run.
